// File: rtl/ofm_wb_pkg.sv
// ofm_wb_pkg: shared types and constants for the OFM write-back block.
//   state_t   : write-back FSM states (IDLE, RUN, DRAIN, DONE)
//   pix_vec_t : one output pixel's worth of activated bytes (16 x 8 bit),
//               channel 16*tile + i lives in bits [8*i+7 : 8*i]
package ofm_wb_pkg;

    localparam int PE_COUNT        = 16;
    localparam int BYTES_PER_WORD  = 4;
    localparam int WORDS_PER_PIXEL = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [PE_COUNT*8-1:0] pix_vec_t;

endpackage

// File: rtl/ofm_writeback_if.sv
// ofm_writeback_if: OFM BRAM write port.
//   wr_en   : write request (master -> slave)
//   wr_addr : BRAM word address (master -> slave)
//   wr_data : 32-bit packed word (master -> slave)
//   wr_ready: BRAM accepts the write (slave -> master)
//
// Handshake: a word transfers on a rising clock edge where wr_en && wr_ready.
// Once wr_en is raised, wr_en, wr_addr and wr_data stay constant until that
// transfer happens; wr_ready may change freely and does not depend on wr_en.
interface ofm_writeback_if #(
    parameter int ADDR_W = 32
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ready;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/ofm_wb_fifo.sv
// ofm_wb_fifo: synchronous FIFO of {pixel offset, 128-bit pixel vector}.
//   clk, reset      : clock, synchronous active-low reset (pointers only)
//   push, push_off,
//   push_data       : write one entry; ignored when full
//   pop             : drop the head entry; ignored when empty
//   head_off,
//   head_data       : current head entry (valid while !empty)
//   full, empty     : occupancy flags, derived from registered pointers
module ofm_wb_fifo
    import ofm_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OFF_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [OFF_W-1:0] push_off,
    input  pix_vec_t         push_data,
    input  logic             pop,
    output logic [OFF_W-1:0] head_off,
    output pix_vec_t         head_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = OFF_W + $bits(pix_vec_t);

    logic [ENT_W-1:0] mem_q [DEPTH];
    // One extra wrap bit distinguishes full from empty.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(do_pop);
        {head_off, head_data} = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only visible after it is pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {push_off, push_data};
        end
    end

endmodule

// File: rtl/ofm_writeback.sv
// ofm_writeback: captures 16 activated bytes per output pixel from the PE
// cluster, buffers them, and writes each pixel as four 32-bit words into the
// OFM BRAM at NHWC-packed word addresses
//   addr = base + pix*(OFM_C/4) + tile*4 + word.
//
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   start               : one-cycle pulse in IDLE; latches base_addr
//   base_addr           : word address of channel 0, pixel 0
//   valid[15:0]         : per-PE result valid
//   ofm_active_0..15    : activated bytes, channel 16*tile + index
//   wr                  : BRAM write port (ofm_writeback_if.master)
//   busy                : high in RUN and DRAIN
//   done                : one-cycle pulse after the last word is accepted
//   overflow_err        : sticky, a capture was dropped on a full FIFO
//   valid_mismatch_err  : sticky, valid was neither all-0 nor all-1
//                         (only with OFM_WB_VALID_CHECK_EN defined)
//   dbg_state           : current FSM state
//
// Build option OFM_WB_VALID_CHECK_EN: adds valid_mismatch_err and requires
// valid == 16'hFFFF to capture; otherwise valid[0] alone gates capture.
module ofm_writeback
    import ofm_wb_pkg::*;
#(
    parameter int OFM_W      = 56,
    parameter int OFM_H      = 56,
    parameter int OFM_C      = 128,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [PE_COUNT-1:0] valid,
    input  logic [7:0]          ofm_active_0,
    input  logic [7:0]          ofm_active_1,
    input  logic [7:0]          ofm_active_2,
    input  logic [7:0]          ofm_active_3,
    input  logic [7:0]          ofm_active_4,
    input  logic [7:0]          ofm_active_5,
    input  logic [7:0]          ofm_active_6,
    input  logic [7:0]          ofm_active_7,
    input  logic [7:0]          ofm_active_8,
    input  logic [7:0]          ofm_active_9,
    input  logic [7:0]          ofm_active_10,
    input  logic [7:0]          ofm_active_11,
    input  logic [7:0]          ofm_active_12,
    input  logic [7:0]          ofm_active_13,
    input  logic [7:0]          ofm_active_14,
    input  logic [7:0]          ofm_active_15,
    ofm_writeback_if.master     wr,
    output logic                busy,
    output logic                done,
    output logic                overflow_err,
`ifdef OFM_WB_VALID_CHECK_EN
    output logic                valid_mismatch_err,
`endif
    output state_t              dbg_state
);
    localparam int NPIX   = OFM_W * OFM_H;
    localparam int NTILE  = OFM_C / PE_COUNT;
    localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int TILE_W = (NTILE > 1) ? $clog2(NTILE) : 1;
    localparam int WORD_W = $clog2(WORDS_PER_PIXEL);
    localparam logic [ADDR_W-1:0] PIX_STRIDE  = ADDR_W'(OFM_C / BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] TILE_STRIDE = ADDR_W'(WORDS_PER_PIXEL);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [TILE_W-1:0]   tile_cnt_q, tile_cnt_d;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
    logic                overflow_q, overflow_d;

    pix_vec_t            cap_data;
    logic                cap_gate, cap_req, pix_last, tile_last;
    logic [ADDR_W-1:0]   cap_off, head_off;
    pix_vec_t            head_data;
    logic                fifo_full, fifo_empty, fifo_pop, word_acc;

    assign cap_data = {ofm_active_15, ofm_active_14, ofm_active_13, ofm_active_12,
                       ofm_active_11, ofm_active_10, ofm_active_9,  ofm_active_8,
                       ofm_active_7,  ofm_active_6,  ofm_active_5,  ofm_active_4,
                       ofm_active_3,  ofm_active_2,  ofm_active_1,  ofm_active_0};

`ifdef OFM_WB_VALID_CHECK_EN
    logic vmm_q, vmm_d;

    assign cap_gate           = (valid == '1);
    assign vmm_d              = vmm_q | ((valid != '0) && (valid != '1));
    assign valid_mismatch_err = vmm_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vmm_q <= 1'b0;
        end else begin
            vmm_q <= vmm_d;
        end
    end
`else
    logic unused_valid;

    assign cap_gate     = valid[0];
    assign unused_valid = ^valid[PE_COUNT-1:1];
`endif

    // Offset of the pixel being captured, relative to base.
    assign cap_off = ADDR_W'(pix_cnt_q) * PIX_STRIDE + ADDR_W'(tile_cnt_q) * TILE_STRIDE;

    // FSM and capture counters. A capture attempt advances the counters even
    // when the FIFO is full, so later pixels keep their correct addresses.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        pix_cnt_d  = pix_cnt_q;
        tile_cnt_d = tile_cnt_q;
        overflow_d = overflow_q;
        cap_req    = (state_q == RUN) && cap_gate;
        pix_last   = (pix_cnt_q == PIX_W'(NPIX - 1));
        tile_last  = (tile_cnt_q == TILE_W'(NTILE - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    base_d     = base_addr;
                    pix_cnt_d  = '0;
                    tile_cnt_d = '0;
                end
            end
            RUN: begin
                if (cap_req) begin
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end
                    if (pix_last) begin
                        pix_cnt_d = '0;
                        if (tile_last) begin
                            tile_cnt_d = '0;
                            state_d    = DRAIN;
                        end else begin
                            tile_cnt_d = tile_cnt_q + 1'b1;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            // Empty FIFO means every buffered word has been accepted.
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write side: serialise the head entry, word_cnt selects the 32-bit lane.
    always_comb begin
        word_acc    = !fifo_empty && wr.wr_ready;
        fifo_pop    = word_acc && (word_cnt_q == WORD_W'(WORDS_PER_PIXEL - 1));
        word_cnt_d  = word_acc ? word_cnt_q + 1'b1 : word_cnt_q;
        wr.wr_en    = !fifo_empty;
        wr.wr_addr  = '0;
        wr.wr_data  = '0;
        if (!fifo_empty) begin
            wr.wr_addr = base_q + head_off + ADDR_W'(word_cnt_q);
            wr.wr_data = head_data[{word_cnt_q, 5'b0} +: 32];
        end
    end

    ofm_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .OFF_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cap_req),
        .push_off  (cap_off),
        .push_data (cap_data),
        .pop       (fifo_pop),
        .head_off  (head_off),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            pix_cnt_q  <= '0;
            tile_cnt_q <= '0;
            word_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            pix_cnt_q  <= pix_cnt_d;
            tile_cnt_q <= tile_cnt_d;
            word_cnt_q <= word_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign overflow_err = overflow_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// tb_ofm_writeback: three ofm_writeback instances sharing clock, reset and PE
// inputs (only one is started at a time):
//   dut 0: 2x1 map, 16 channels   dut 1: 1x1 map, 32 channels
//   dut 2: 4x1 map, 16 channels
// Expected BRAM writes {dut, addr, data} go into exp_q when stimulus is
// issued; a per-instance monitor pops and compares on each accepted write.
module tb_ofm_writeback;
    import ofm_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start = '0;
    logic [2:0]  rdy = '0;
    logic [31:0] base = '0;
    logic [15:0] valid = '0;
    logic [7:0]  act [16];

    logic [2:0]  wen, busy_w, done_w, ovf_w;
    logic [31:0] waddr [3];
    logic [31:0] wdata [3];
    state_t      st [3];
`ifdef OFM_WB_VALID_CHECK_EN
    logic [2:0]  vmm_w;
`endif

    logic [65:0] exp_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          done_cnt [3];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input logic [7:0] b);
        valid = 16'hFFFF;
        for (int i = 0; i < 16; i++) act[i] = b + 8'(i);
    endtask

    // Four expected words of one pixel whose channel bytes are b, b+1, ...
    task automatic exp_pix(input int g, input logic [31:0] a0, input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] x;
            x = b + 8'(4 * k);
            exp_q.push_back({2'(g), a0 + 32'(k), x + 8'd3, x + 8'd2, x + 8'd1, x});
        end
    endtask

    task automatic wait_done(input int g, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done_w[g]) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 66'(seen), 66'd1);
        check("busy_low_at_done", 66'(busy_w[g]), 66'd0);
        tick(3);
        check("done_pulse_count", 66'(done_cnt[g]), 66'd1);
        check("queue_drained", 66'(exp_q.size()), 66'd0);
        check("state_idle_after", 66'(st[g]), 66'(IDLE));
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        localparam int C = (g == 1) ? 32 : 16;

        ofm_writeback_if #(.ADDR_W(32)) bus ();
        assign bus.wr_ready = rdy[g];
        assign wen[g]   = bus.wr_en;
        assign waddr[g] = bus.wr_addr;
        assign wdata[g] = bus.wr_data;

        ofm_writeback #(
            .OFM_W(W), .OFM_H(1), .OFM_C(C), .ADDR_W(32), .FIFO_DEPTH(2)
        ) u_dut (
            .clk(clk), .reset(rst_n), .start(start[g]), .base_addr(base), .valid(valid),
            .ofm_active_0(act[0]),   .ofm_active_1(act[1]),   .ofm_active_2(act[2]),
            .ofm_active_3(act[3]),   .ofm_active_4(act[4]),   .ofm_active_5(act[5]),
            .ofm_active_6(act[6]),   .ofm_active_7(act[7]),   .ofm_active_8(act[8]),
            .ofm_active_9(act[9]),   .ofm_active_10(act[10]), .ofm_active_11(act[11]),
            .ofm_active_12(act[12]), .ofm_active_13(act[13]), .ofm_active_14(act[14]),
            .ofm_active_15(act[15]),
            .wr(bus), .busy(busy_w[g]), .done(done_w[g]), .overflow_err(ovf_w[g]),
`ifdef OFM_WB_VALID_CHECK_EN
            .valid_mismatch_err(vmm_w[g]),
`endif
            .dbg_state(st[g])
        );

        logic        prev_stall = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [31:0] prev_data = '0;
        logic [65:0] e;

        always @(negedge clk) begin
            if (rst_n) begin
                if (prev_stall)
                    check("hold_stable", {2'b0, bus.wr_en, bus.wr_addr, bus.wr_data},
                          {2'b0, 1'b1, prev_addr, prev_data});
                if (bus.wr_en && rdy[g]) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_write: dut %0d addr %h data %h, none expected",
                                 g, bus.wr_addr, bus.wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("write", {2'(g), bus.wr_addr, bus.wr_data}, e);
                    end
                end
                if (done_w[g]) done_cnt[g] = done_cnt[g] + 1;
                prev_stall <= bus.wr_en && !rdy[g];
                prev_addr  <= bus.wr_addr;
                prev_data  <= bus.wr_data;
            end else begin
                prev_stall <= 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) act[i] = '0;
        for (int g = 0; g < 3; g++) done_cnt[g] = 0;

        // Reset hold: every output cleared.
        tick(3);
        for (int g = 0; g < 3; g++) begin
            check("rst_wr_en", 66'(wen[g]), 66'd0);
            check("rst_wr_addr", 66'(waddr[g]), 66'd0);
            check("rst_wr_data", 66'(wdata[g]), 66'd0);
            check("rst_busy", 66'(busy_w[g]), 66'd0);
            check("rst_done", 66'(done_w[g]), 66'd0);
            check("rst_overflow", 66'(ovf_w[g]), 66'd0);
            check("rst_state", 66'(st[g]), 66'(IDLE));
        end
        rst_n = 1'b1;
        rdy   = 3'b111;
        tick(2);

        // valid without start: no writes.
        drive_pix(8'hEE);
        tick(3);
        valid = '0;
        tick(3);
        for (int g = 0; g < 3; g++) begin
            check("idle_no_wr_en", 66'(wen[g]), 66'd0);
            check("idle_state", 66'(st[g]), 66'(IDLE));
        end

        // 2x1x16 layer at 0x100, two back-to-back pixels.
        exp_pix(0, 32'h100, 8'h00);
        exp_pix(0, 32'h104, 8'h10);
        base = 32'h100;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        check("busy_after_start", 66'(busy_w[0]), 66'd1);
        drive_pix(8'h00);
        @(negedge clk);
        check("wr_en_before_capture", 66'(wen[0]), 66'd0);
        tick(1);
        drive_pix(8'h10);
        @(negedge clk);
        check("first_wr_en", 66'(wen[0]), 66'd1);
        check("first_wr_addr", 66'(waddr[0]), 66'h100);
        check("first_wr_data", 66'(wdata[0]), 66'h03020100);
        tick(1);
        valid = '0;
        wait_done(0, 40);

        // 1x1x32 layer at 0: tile 1 lands at words 4..7.
        done_cnt[1] = 0;
        exp_pix(1, 32'h0, 8'h20);
        exp_pix(1, 32'h4, 8'h40);
        base = 32'h0;
        start[1] = 1'b1;
        tick(1);
        start[1] = 1'b0;
        drive_pix(8'h20);
        tick(1);
        drive_pix(8'h40);
        tick(1);
        valid = '0;
        wait_done(1, 40);

        // Backpressure for 5 cycles mid-pixel.
        done_cnt[0] = 0;
        exp_pix(0, 32'h300, 8'h50);
        exp_pix(0, 32'h304, 8'h60);
        base = 32'h300;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        drive_pix(8'h50);
        tick(1);
        drive_pix(8'h60);
        tick(1);
        valid = '0;
        tick(1);
        rdy[0] = 1'b0;
        tick(5);
        rdy[0] = 1'b1;
        wait_done(0, 40);

        // Overflow: three captures into a 2-deep FIFO with BRAM stalled.
        exp_pix(2, 32'h400, 8'h70);
        exp_pix(2, 32'h404, 8'h80);
        rdy[2] = 1'b0;
        base = 32'h400;
        start[2] = 1'b1;
        tick(1);
        start[2] = 1'b0;
        drive_pix(8'h70);
        tick(1);
        drive_pix(8'h80);
        tick(1);
        drive_pix(8'h90);
        @(negedge clk);
        check("overflow_before_drop", 66'(ovf_w[2]), 66'd0);
        tick(1);
        valid = '0;
        @(negedge clk);
        check("overflow_set", 66'(ovf_w[2]), 66'd1);
        tick(1);
        rdy[2] = 1'b1;
        tick(10);
        exp_pix(2, 32'h40C, 8'hA0);
        drive_pix(8'hA0);
        tick(1);
        valid = '0;
        wait_done(2, 40);
        check("overflow_sticky", 66'(ovf_w[2]), 66'd1);

        // Reset mid-RUN with one pixel still buffered, then a fresh layer.
        rdy[2] = 1'b0;
        base = 32'h500;
        start[2] = 1'b1;
        tick(1);
        start[2] = 1'b0;
        drive_pix(8'hB0);
        tick(1);
        valid = '0;
        tick(1);
        rst_n = 1'b0;
        tick(2);
        check("midrst_wr_en", 66'(wen[2]), 66'd0);
        check("midrst_busy", 66'(busy_w[2]), 66'd0);
        check("midrst_overflow", 66'(ovf_w[2]), 66'd0);
        check("midrst_state", 66'(st[2]), 66'(IDLE));
        rst_n = 1'b1;
        rdy[2] = 1'b1;
        tick(2);
        check("postrst_no_wr", 66'(wen[2]), 66'd0);
        done_cnt[2] = 0;
        base = 32'h200;
        start[2] = 1'b1;
        tick(1);
        start[2] = 1'b0;
        for (int p = 0; p < 4; p++) begin
            exp_pix(2, 32'h200 + 32'(4 * p), 8'hC0 + 8'(16 * p));
            drive_pix(8'hC0 + 8'(16 * p));
            tick(1);
            valid = '0;
            tick(3);
        end
        wait_done(2, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
